// File: rtl/edge_detect_pkg.sv
// Shared types and arithmetic for the edge_detect pipeline.
//   state_t   : sobel_filter sequencing states
//   pixel_t   : 8-bit grayscale / magnitude sample
//   grad_t    : 11-bit signed gradient component
//   win_t     : 3x3 window, indexed [row][col], row 0 = oldest (top) row
//   sobel_mag : saturated (|gx|+|gy|)>>1 for one 3x3 window
package edge_detect_pkg;

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

  typedef logic [7:0] pixel_t;
  typedef logic signed [10:0] grad_t;
  typedef pixel_t [2:0][2:0] win_t;

  function automatic pixel_t sobel_mag(input win_t w);
    logic [10:0] pos_x, neg_x, pos_y, neg_y;
    logic [10:0] abs_x, abs_y, sum, mag;
    grad_t gx, gy;
    // Each weighted sum is at most 4*255 = 1020, so 11 bits hold it and the
    // difference fits an 11-bit signed value without overflow.
    pos_x = {3'b0, w[0][2]} + {2'b0, w[1][2], 1'b0} + {3'b0, w[2][2]};
    neg_x = {3'b0, w[0][0]} + {2'b0, w[1][0], 1'b0} + {3'b0, w[2][0]};
    pos_y = {3'b0, w[2][0]} + {2'b0, w[2][1], 1'b0} + {3'b0, w[2][2]};
    neg_y = {3'b0, w[0][0]} + {2'b0, w[0][1], 1'b0} + {3'b0, w[0][2]};
    gx    = grad_t'(pos_x - neg_x);
    gy    = grad_t'(pos_y - neg_y);
    abs_x = gx[10] ? 11'(-gx) : 11'(gx);
    abs_y = gy[10] ? 11'(-gy) : 11'(gy);
    // |gx|+|gy| <= 2040 still fits 11 unsigned bits.
    sum   = abs_x + abs_y;
    mag   = sum >> 1;
    return (mag > 11'd255) ? 8'hFF : mag[7:0];
  endfunction

endpackage

// File: rtl/sobel_window.sv
// Two-line-plus-three shift register feeding the 3x3 Sobel window.
//   clock, reset   : clock, async active-low reset (clears every stage)
//   i_shift_en     : advance the window by one pixel
//   i_shift_in     : pixel entering the window
//   o_taps         : 3x3 window [row][col]; [2][2] is the newest pixel
module sobel_window
  import edge_detect_pkg::*;
#(
  parameter int WIDTH = 720
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   i_shift_en,
  input  pixel_t i_shift_in,
  output win_t   o_taps
);

  localparam int LEN = 2 * WIDTH + 3;

  // Stage 0 is the newest pixel; stage WIDTH is the same column one row up.
  pixel_t r_sr [LEN];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LEN; i++) r_sr[i] <= '0;
    end else if (i_shift_en) begin
      r_sr[0] <= i_shift_in;
      for (int i = 1; i < LEN; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_taps[2][2] = r_sr[0];
  assign o_taps[2][1] = r_sr[1];
  assign o_taps[2][0] = r_sr[2];
  assign o_taps[1][2] = r_sr[WIDTH];
  assign o_taps[1][1] = r_sr[WIDTH+1];
  assign o_taps[1][0] = r_sr[WIDTH+2];
  assign o_taps[0][2] = r_sr[2*WIDTH];
  assign o_taps[0][1] = r_sr[2*WIDTH+1];
  assign o_taps[0][0] = r_sr[2*WIDTH+2];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel magnitude stage between the grayscale FIFO and the
// output FIFO. One WIDTH x HEIGHT frame per pass, raster order.
//   clock, reset          : clock, async active-low reset
//   in_empty/in_rd_en/in_dout   : upstream FIFO (pop when in_rd_en=1)
//   out_full/out_wr_en/out_din  : downstream FIFO (push when out_wr_en=1)
//   o_dbg_state           : current sequencing state (FILL/RUN/DRAIN)
// Handshake: a pop happens on a rising edge where in_rd_en=1 (only when
// in_empty=0); a push happens on a rising edge where out_wr_en=1 (only when
// out_full=0). In RUN every pop is paired with a push in the same cycle.
module sobel_filter
  import edge_detect_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   in_empty,
  output logic   in_rd_en,
  input  pixel_t in_dout,
  input  logic   out_full,
  output logic   out_wr_en,
  output pixel_t out_din,
  output state_t o_dbg_state
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);

  state_t          r_state;
  logic [CW-1:0]   r_rd_cnt;
  logic [XW-1:0]   r_col;   // column of the window center
  logic [YW-1:0]   r_row;   // row of the window center
  logic            w_rd;
  logic            w_wr;
  logic            w_shift_en;
  pixel_t          w_shift_in;
  logic            w_last;
  logic            w_border;
  win_t            w_taps;

  // Gating with reset keeps both strobes low while reset is held.
  always_comb begin
    w_rd = 1'b0;
    w_wr = 1'b0;
    case (r_state)
      FILL:    w_rd = !in_empty;
      RUN:     begin
                 w_rd = !in_empty && !out_full;
                 w_wr = !in_empty && !out_full;
               end
      DRAIN:   w_wr = !out_full;
      default: ;
    endcase
    w_rd = w_rd && reset;
    w_wr = w_wr && reset;
  end

  // DRAIN pushes zeros through so the final rows' centers reach their taps.
  assign w_shift_en = w_rd || ((r_state == DRAIN) && w_wr);
  assign w_shift_in = (r_state == DRAIN) ? 8'h00 : in_dout;

  assign w_last   = (r_row == YW'(HEIGHT - 1)) && (r_col == XW'(WIDTH - 1));
  assign w_border = (r_row == '0) || (r_row == YW'(HEIGHT - 1)) ||
                    (r_col == '0) || (r_col == XW'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= FILL;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        FILL: if (w_rd) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (r_rd_cnt == CW'(WIDTH + 1)) r_state <= RUN;
        end
        RUN: if (w_rd) begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (r_rd_cnt == CW'(NPIX - 1)) r_state <= DRAIN;
        end
        DRAIN: if (w_wr && w_last) begin
          r_state  <= FILL;
          r_rd_cnt <= '0;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Center position doubles as the output index (row*WIDTH + col).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_wr) begin
      if (w_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == XW'(WIDTH - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  sobel_window #(.WIDTH(WIDTH)) u_window (
    .clock      (clock),
    .reset      (reset),
    .i_shift_en (w_shift_en),
    .i_shift_in (w_shift_in),
    .o_taps     (w_taps)
  );

  // Border centers see wrapped or stale pixels, so they are forced to 0.
  assign out_din     = (w_border || !reset) ? 8'h00 : sobel_mag(w_taps);
  assign in_rd_en    = w_rd;
  assign out_wr_en   = w_wr;
  assign o_dbg_state = r_state;

endmodule

// File: doc/sobel_filter.md
Name: sobel_filter

Overview:
- Streaming 3x3 Sobel edge stage inside edge_detect.
- Sits directly downstream of the grayscale stage: it consumes the 8-bit grayscale FIFO and produces 8-bit gradient magnitude into the output FIFO (out_dout side).
- Processes one WIDTH x HEIGHT frame in raster order, then rearms for the next frame.
- Uses a 2-line-plus-3 shift window; no frame buffer.

Parameters:
- WIDTH, 720, pixels per row (>= 3)
- HEIGHT, 540, rows per frame (>= 3)

Ports:
- clock  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- in_empty  in  1  upstream grayscale FIFO empty
- in_rd_en  out  1  pop upstream FIFO this cycle
- in_dout  in  8  upstream FIFO head (grayscale pixel)
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push to downstream FIFO this cycle
- out_din  out  8  Sobel magnitude for the current center pixel

Behaviour:
- Reset (reset=0, async):
  - state=FILL; read count and output index = 0; window cleared to 0.
  - in_rd_en=0, out_wr_en=0, out_din=0 while asserted.
  - Reset mid-frame discards the partial frame; the next frame starts clean after deassertion.
- Window: a shift register of 2*WIDTH+3 pixels.
  - An "advance" shifts in one pixel.
  - With N pixels read, the center is pixel k = N-WIDTH-2, at (r,c) = (k/WIDTH, k%WIDTH).
- State FILL:
  - in_rd_en = !in_empty; each read advances the window.
  - Go to RUN when the read count reaches WIDTH+2.
  - out_wr_en=0.
- State RUN:
  - in_rd_en = out_wr_en = !in_empty && !out_full. A read and a write always occur together.
  - Advance on each read; output index increments on each write.
  - Go to DRAIN when the read count reaches WIDTH*HEIGHT.
- State DRAIN:
  - in_rd_en=0; out_wr_en = !out_full; each write advances the window, inserting 0.
  - After writing index WIDTH*HEIGHT-1, go to FILL with counters cleared.
  - Total outputs per frame: exactly WIDTH*HEIGHT, in raster order.
- out_din is combinational from the window registers and the row/col of the center pixel. It is valid whenever out_wr_en=1.
- Border rule: r==0, r==HEIGHT-1, c==0 or c==WIDTH-1 gives out_din=0. Padding and wrap pixels never leak into the output.
- Arithmetic (window p[row][col], row/col 0..2, center p[1][1]):
  - gx = (p02+2*p12+p22) - (p00+2*p10+p20), 11-bit signed.
  - gy = (p20+2*p21+p22) - (p00+2*p01+p02), 11-bit signed.
  - mag = (|gx|+|gy|) >> 1, 11-bit unsigned (max 1020).
  - out_din = mag > 255 ? 255 : mag[7:0].
- Latency: the first write is possible in the cycle after the (WIDTH+2)th read. Steady-state throughput is 1 pixel/cycle.
- Backpressure: out_full=1 stalls reads in RUN; nothing is lost or duplicated.
- in_empty=1 in RUN stalls writes even if out_full=0.
- A frame of WIDTH*HEIGHT reads is assumed; extra input is not consumed until DRAIN completes.

Decomposition:
- Shared package edge_detect_pkg:
  - state enum {FILL, RUN, DRAIN}
  - pixel_t (8-bit)
  - grad_t (11-bit signed)
  - function sobel_mag(3x3 window) returning 8-bit saturated magnitude
- One sub-module: sobel_window (WIDTH param). Holds the shift-register line buffer, with shift_en/shift_in and exposing the 9 taps.
- sobel_filter holds the FSM, counters, border mask and arithmetic.

Test Plan:
- WIDTH=4, HEIGHT=4, all pixels 100, FIFOs never full/empty -> 16 outputs, all 0; first out_wr_en one cycle after the 6th read.
- WIDTH=8, HEIGHT=4, pixel = 10*col -> interior outputs (r=1,2; c=1..6) = 40; border outputs 0; exactly 32 writes.
- WIDTH=8, HEIGHT=4, cols 0-3 = 0, cols 4-7 = 255 -> at c=3,4 interior, gx=1020, mag 510 clamps to 255; other interior pixels 0.
- Random image with out_full toggling on a 37% random pattern and in_empty random -> output stream bit-exact to the software model; in_rd_en never 1 while out_full=1 in RUN; no write while out_full=1.
- Reset driven low mid-RUN (after 20 reads of an 8x4 frame) -> outputs go 0 immediately; a following full frame of constant 50 gives 32 zeros with correct count.
- Two back-to-back 8x4 frames with no idle gap -> 64 writes total; frame 2 outputs are unaffected by frame 1 pixels, including row 0 and row 3 borders.
